// File: rtl/pipe_stage_reg_if.sv
// Bundle for one inter-stage pipeline register: upstream valid/control/lanes, stall/flush controls, registered outputs and counters.
// Latency: none (wires only). The master drives the stage inputs and the slave drives the registered outputs.
// Backpressure: STALL and FLUSH are carried to the register; there is no ready return path.
interface pipe_stage_reg_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 3,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
);
    logic                        STALL;
    logic                        FLUSH;
    logic                        CNT_CLR;
    logic                        VALID_IN;
    logic [CTRL_W-1:0]           CTRL_IN;
    logic [NUM_LANES*DATA_W-1:0] DATA_IN;
    logic                        VALID_OUT;
    logic [CTRL_W-1:0]           CTRL_OUT;
    logic [NUM_LANES*DATA_W-1:0] DATA_OUT;
    logic                        HELD;
    logic [CNT_W-1:0]            STALL_CYCLES;
    logic [CNT_W-1:0]            FLUSH_KILLS;

    modport master (
        output STALL, FLUSH, CNT_CLR, VALID_IN, CTRL_IN, DATA_IN,
        input  VALID_OUT, CTRL_OUT, DATA_OUT, HELD, STALL_CYCLES, FLUSH_KILLS
    );

    modport slave (
        input  STALL, FLUSH, CNT_CLR, VALID_IN, CTRL_IN, DATA_IN,
        output VALID_OUT, CTRL_OUT, DATA_OUT, HELD, STALL_CYCLES, FLUSH_KILLS
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic RV32IM inter-stage register (valid, control, NUM_LANES lanes) with saturating stall/flush counters; PIPE_FLUSH_DATA_CLEAR_EN zeroes lanes on flush.
// Latency: 1 cycle from inputs to outputs on a load edge; every output comes straight from a flop.
// Backpressure: STALL holds all contents indefinitely; FLUSH overrides STALL and inserts a bubble.
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                NUM_LANES   = 3,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input logic             CLK,
    input logic             RESET,
    pipe_stage_reg_if.slave bus
);
    localparam int BUS_W = NUM_LANES * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [BUS_W-1:0]  data;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic             do_flush, do_stall;

    assign do_flush = bus.FLUSH;
    assign do_stall = bus.STALL & ~bus.FLUSH;

    always_comb begin
        stage_d = stage_q;
        held_d  = held_q;
        if (do_flush) begin
            stage_d.valid = 1'b0;
            stage_d.ctrl  = CTRL_BUBBLE;
            held_d        = 1'b0;
`ifdef PIPE_FLUSH_DATA_CLEAR_EN
            stage_d.data  = '0;
`endif
        end else if (do_stall) begin
            held_d = 1'b1;
        end else begin
            // Control is valid-qualified so an empty slot can never carry write enables.
            stage_d.valid = bus.VALID_IN;
            stage_d.ctrl  = bus.VALID_IN ? bus.CTRL_IN : CTRL_BUBBLE;
            for (int k = 0; k < NUM_LANES; k++) begin
                stage_d.data[k*DATA_W +: DATA_W] = bus.DATA_IN[k*DATA_W +: DATA_W];
            end
            held_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (bus.CNT_CLR) begin
            stall_cnt_d = '0;
            kill_cnt_d  = '0;
        end else begin
            if (do_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            // Only flushes that destroy a real instruction are counted.
            if (do_flush && stage_q.valid && (kill_cnt_q != CNT_MAX)) begin
                kill_cnt_d = kill_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stage_q.valid <= 1'b0;
            stage_q.ctrl  <= CTRL_BUBBLE;
            stage_q.data  <= '0;
            held_q        <= 1'b0;
            stall_cnt_q   <= '0;
            kill_cnt_q    <= '0;
        end else begin
            stage_q     <= stage_d;
            held_q      <= held_d;
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign bus.VALID_OUT    = stage_q.valid;
    assign bus.CTRL_OUT     = stage_q.ctrl;
    assign bus.DATA_OUT     = stage_q.data;
    assign bus.HELD         = held_q;
    assign bus.STALL_CYCLES = stall_cnt_q;
    assign bus.FLUSH_KILLS  = kill_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed and random stimulus, expected outputs from a stage-contents model queued per edge
// and checked by an independent monitor after every rising edge or asynchronous reset.
module tb_pipe_stage_reg;
    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 3;
    localparam int CTRL_W    = 8;
    localparam int CNT_W     = 4;
    localparam int BUS_W     = DATA_W * NUM_LANES;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;
    localparam logic [CTRL_W-1:0] BUB = '0;
    localparam logic [BUS_W-1:0] D0 = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010};

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(
        .DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W),
        .CTRL_BUBBLE(BUB), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    typedef struct {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [BUS_W-1:0]  data;
        logic              held;
        int                stalls;
        int                kills;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    // Reference model: what the stage holds, plus unbounded event tallies clipped on output.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_lane [NUM_LANES];
    logic              m_held;
    int                m_stalls;
    int                m_kills;

    function automatic int clip(input int n);
        return (n > CNT_SAT) ? CNT_SAT : n;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.valid = m_valid;
        e.ctrl  = m_ctrl;
        for (int k = 0; k < NUM_LANES; k++) e.data[k*DATA_W +: DATA_W] = m_lane[k];
        e.held   = m_held;
        e.stalls = clip(m_stalls);
        e.kills  = clip(m_kills);
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_ctrl  = BUB;
        for (int k = 0; k < NUM_LANES; k++) m_lane[k] = '0;
        m_held   = 1'b0;
        m_stalls = 0;
        m_kills  = 0;
    endfunction

    function automatic void model_edge(input logic stall, input logic flush, input logic clr,
                                       input logic vin, input logic [CTRL_W-1:0] ctrl,
                                       input logic [BUS_W-1:0] data);
        if (flush) begin
            if (m_valid) m_kills++;
            m_valid = 1'b0;
            m_ctrl  = BUB;
            m_held  = 1'b0;
`ifdef PIPE_FLUSH_DATA_CLEAR_EN
            for (int k = 0; k < NUM_LANES; k++) m_lane[k] = '0;
`endif
        end else if (stall) begin
            m_held = 1'b1;
            m_stalls++;
        end else begin
            m_valid = vin;
            m_ctrl  = vin ? ctrl : BUB;
            for (int k = 0; k < NUM_LANES; k++) m_lane[k] = data[k*DATA_W +: DATA_W];
            m_held = 1'b0;
        end
        if (clr) begin
            m_stalls = 0;
            m_kills  = 0;
        end
    endfunction

    function automatic logic [BUS_W-1:0] rnd_data();
        logic [BUS_W-1:0] d;
        for (int k = 0; k < NUM_LANES; k++) d[k*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    task automatic drive(input logic stall, input logic flush, input logic clr, input logic vin,
                         input logic [CTRL_W-1:0] ctrl, input logic [BUS_W-1:0] data);
        @(negedge CLK);
        RESET        = 1'b0;
        bus.STALL    = stall;
        bus.FLUSH    = flush;
        bus.CNT_CLR  = clr;
        bus.VALID_IN = vin;
        bus.CTRL_IN  = ctrl;
        bus.DATA_IN  = data;
        model_edge(stall, flush, clr, vin, ctrl, data);
        push_exp();
    endtask

    // Asserted mid-cycle and held through the following edge.
    task automatic pulse_reset();
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
        push_exp();
        push_exp();
        ->chk_ev;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_out",    128'(bus.VALID_OUT),    128'(e.valid));
                chk("ctrl_out",     128'(bus.CTRL_OUT),     128'(e.ctrl));
                chk("data_out",     128'(bus.DATA_OUT),     128'(e.data));
                chk("held",         128'(bus.HELD),         128'(e.held));
                chk("stall_cycles", 128'(bus.STALL_CYCLES), 128'(e.stalls));
                chk("flush_kills",  128'(bus.FLUSH_KILLS),  128'(e.kills));
            end
        end
    end

    initial begin
        int w;
        int r;
        bus.STALL    = 1'b0;
        bus.FLUSH    = 1'b0;
        bus.CNT_CLR  = 1'b0;
        bus.VALID_IN = 1'b0;
        bus.CTRL_IN  = '0;
        bus.DATA_IN  = '0;
        model_reset();

        // Reset, load, then reset again with non-zero contents and counters.
        pulse_reset();
        drive(0, 0, 0, 1, 8'hA5, D0);
        drive(1, 0, 0, 1, 8'h3C, rnd_data());
        drive(0, 0, 0, 1, 8'h3C, rnd_data());
        pulse_reset();
        drive(0, 0, 0, 1, 8'hA5, D0);

        // Five-edge stall with changing inputs, then release.
        repeat (5) drive(1, 0, 0, 1'($urandom), CTRL_W'($urandom), rnd_data());
        drive(0, 0, 0, 1, 8'h5A, rnd_data());

        // Flush beats stall on a valid entry, then flush of a bubble.
        drive(1, 1, 0, 1, 8'h77, rnd_data());
        drive(0, 1, 0, 1, 8'h66, rnd_data());

        // Invalid slot drops its control.
        drive(0, 0, 0, 0, 8'hFF, rnd_data());

        // Stall counter saturation, then clear on a stall edge.
        repeat (20) drive(1, 0, 0, 1, 8'h11, rnd_data());
        drive(1, 0, 1, 1, 8'h22, rnd_data());
        drive(0, 0, 0, 1, 8'h33, rnd_data());

        // Kill counter saturation.
        repeat (20) begin
            drive(0, 0, 0, 1, 8'h44, rnd_data());
            drive(0, 1, 0, 1, 8'h44, rnd_data());
        end
        drive(0, 1, 1, 1, 8'h55, rnd_data());

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12,
                      $urandom_range(0, 99) < 3, 1'($urandom),
                      CTRL_W'($urandom), rnd_data());
            end
        end

        w = 0;
        while (exp_q.size() > 0 && w < 20) begin
            @(posedge CLK);
            w++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
